// File: rtl/iram_loader_ctrl.sv
// Instruction-RAM controller: arbitrates a byte-wide program loader (LOAD mode)
// and pipelined CPU fetches (RUN mode) onto one single-port synchronous RAM.
module iram_loader_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LOAD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              ld_valid,
  input  logic [LOAD_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int BEATS  = DATA_W / LOAD_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] PTR_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_LOAD_ASM,
    S_LOAD_WR,
    S_LOAD_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                done_q, done_d;
  logic                rd_pend_q, rd_pend_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0]   fetch_hold_q, fetch_hold_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                ld_ready_c;
  logic [DATA_W-1:0]   asm_merged;

  // Current beat dropped into its little-endian lane of the word being built.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign asm_merged[gi*LOAD_W +: LOAD_W] =
      (beat_q == BEAT_W'(gi)) ? ld_data : asm_q[gi*LOAD_W +: LOAD_W];
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    beat_d        = beat_q;
    asm_d         = asm_q;
    count_d       = count_q;
    done_d        = done_q;
    rd_pend_d     = 1'b0;
    fetch_valid_d = rd_pend_q;
    fetch_hold_d  = fetch_valid_q ? ram_rdata : fetch_hold_q;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    ld_ready_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A fetch in the same cycle load_en rises is still served; DRAIN waits for it.
        if (fetch_req) begin
          rd_pend_d  = 1'b1;
          ram_addr_d = fetch_addr;
        end
        if (load_en) state_d = S_DRAIN;
      end

      S_DRAIN: begin
        if (!load_en) begin
          state_d = S_IDLE;
        end else if (!rd_pend_q) begin
          state_d = S_LOAD_ASM;
          ptr_d   = '0;
          beat_d  = '0;
          asm_d   = '0;
          count_d = '0;
          done_d  = 1'b0;
        end
      end

      S_LOAD_ASM: begin
        if (!load_en) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else begin
          ld_ready_c = 1'b1;
          if (ld_valid) begin
            asm_d = asm_merged;
            if (beat_q == LAST_BEAT) begin
              // Write strobe is registered so it is high exactly during LOAD_WR.
              beat_d      = '0;
              state_d     = S_LOAD_WR;
              ram_we_d    = 1'b1;
              ram_addr_d  = ptr_q;
              ram_wdata_d = asm_merged;
            end else begin
              beat_d = beat_q + BEAT_W'(1);
            end
          end
        end
      end

      S_LOAD_WR: begin
        ptr_d   = ptr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W + 1)'(1);
        if (ptr_q == PTR_MAX) begin
          done_d  = 1'b1;
          state_d = load_en ? S_LOAD_DONE : S_IDLE;
        end else begin
          state_d = load_en ? S_LOAD_ASM : S_IDLE;
        end
      end

      S_LOAD_DONE: begin
        if (!load_en) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      beat_q        <= '0;
      asm_q         <= '0;
      count_q       <= '0;
      done_q        <= 1'b0;
      rd_pend_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_hold_q  <= '0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      beat_q        <= beat_d;
      asm_q         <= asm_d;
      count_q       <= count_d;
      done_q        <= done_d;
      rd_pend_q     <= rd_pend_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_hold_q  <= fetch_hold_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
    end
  end

  // RAM data is forwarded in its arrival cycle for 2-cycle latency; the hold
  // register keeps the last delivered word visible between fetches.
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_valid_q ? ram_rdata : fetch_hold_q;
  assign fetch_busy  = (state_q != S_IDLE);
  assign ld_ready    = ld_ready_c;
  assign ld_done     = done_q;
  assign ld_count    = count_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;

endmodule
